fwnoc_host_ep: RTL and testbench

Host-side network endpoint that attaches to a router's host port and terminates the fwnoc packet protocol at the host. On the transmit path it packetizes user requests, prepending a routing header to a payload stream and driving them into the router's host ingress. On the receive path it accepts packets from the router's host egress, checks the destination, strips the header and presents source, length and payload to the user. Each mesh tile holds one instance, with parameters matching its router.

---
 rtl/fwnoc_host_ep.sv | 183 ++++++++++++++++++
 tb/tb_fwnoc_host_ep.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fwnoc_host_ep.sv
// Host-side fwnoc endpoint: packetizes user TX requests onto the router ingress
// and depacketizes router egress traffic addressed to this tile.
module fwnoc_host_ep #(
  parameter int X_ID = 0,
  parameter int Y_ID = 0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] noc_e_dat,
  output logic        noc_e_valid,
  input  logic        noc_e_ready,
  input  logic [31:0] noc_i_dat,
  input  logic        noc_i_valid,
  output logic        noc_i_ready,
  input  logic        tx_req_valid,
  output logic        tx_req_ready,
  input  logic [1:0]  tx_dst_x,
  input  logic [1:0]  tx_dst_y,
  input  logic [7:0]  tx_len,
  input  logic [31:0] tx_dat,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_err,
  output logic        rx_hdr_valid,
  output logic [1:0]  rx_src_x,
  output logic [1:0]  rx_src_y,
  output logic [7:0]  rx_len,
  output logic [31:0] rx_dat,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_last,
  output logic [7:0]  rx_drop_cnt
);
  localparam logic [1:0] MY_X = X_ID[1:0];
  localparam logic [1:0] MY_Y = Y_ID[1:0];

  typedef enum logic [1:0] {T_IDLE, T_HDR, T_BODY, T_DISC} tx_st_e;
  typedef enum logic [1:0] {R_HDR, R_BODY, R_DROP} rx_st_e;

  tx_st_e      tx_st_q;
  logic [3:0]  tx_dst_q;
  logic [7:0]  tx_cnt_q;
  logic        tx_err_q;
  rx_st_e      rx_st_q;
  logic [7:0]  rx_cnt_q;
  logic [1:0]  rx_src_x_q, rx_src_y_q;
  logic [7:0]  rx_len_q, rx_drop_q;
  logic        rx_hdr_q;

  logic tx_self, rx_match;
  assign tx_self  = (tx_dst_x == MY_X) && (tx_dst_y == MY_Y);
  assign rx_match = (noc_i_dat[1:0] == MY_X) && (noc_i_dat[3:2] == MY_Y);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_st_q  <= T_IDLE;
      tx_dst_q <= '0;
      tx_cnt_q <= '0;
      tx_err_q <= 1'b0;
    end else begin
      tx_err_q <= 1'b0;
      case (tx_st_q)
        T_IDLE: if (tx_req_valid) begin
          tx_dst_q <= {tx_dst_y, tx_dst_x};
          tx_cnt_q <= tx_len;
          if (tx_self) begin
            tx_err_q <= 1'b1;
            tx_st_q  <= (tx_len == 8'd0) ? T_IDLE : T_DISC;
          end else begin
            tx_st_q  <= T_HDR;
          end
        end
        T_HDR: if (noc_e_ready) tx_st_q <= (tx_cnt_q == 8'd0) ? T_IDLE : T_BODY;
        T_BODY: if (tx_valid && noc_e_ready) begin
          tx_cnt_q <= tx_cnt_q - 8'd1;
          if (tx_cnt_q == 8'd1) tx_st_q <= T_IDLE;
        end
        T_DISC: if (tx_valid) begin
          tx_cnt_q <= tx_cnt_q - 8'd1;
          if (tx_cnt_q == 8'd1) tx_st_q <= T_IDLE;
        end
        default: tx_st_q <= T_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_st_q    <= R_HDR;
      rx_cnt_q   <= '0;
      rx_src_x_q <= '0;
      rx_src_y_q <= '0;
      rx_len_q   <= '0;
      rx_drop_q  <= '0;
      rx_hdr_q   <= 1'b0;
    end else begin
      rx_hdr_q <= 1'b0;
      case (rx_st_q)
        R_HDR: if (noc_i_valid) begin
          rx_cnt_q <= noc_i_dat[15:8];
          if (rx_match) begin
            rx_src_x_q <= noc_i_dat[5:4];
            rx_src_y_q <= noc_i_dat[7:6];
            rx_len_q   <= noc_i_dat[15:8];
            rx_hdr_q   <= 1'b1;
            rx_st_q    <= (noc_i_dat[15:8] == 8'd0) ? R_HDR : R_BODY;
          end else begin
            if (rx_drop_q != 8'hFF) rx_drop_q <= rx_drop_q + 8'd1;
            rx_st_q <= (noc_i_dat[15:8] == 8'd0) ? R_HDR : R_DROP;
          end
        end
        R_BODY: if (noc_i_valid && rx_ready) begin
          rx_cnt_q <= rx_cnt_q - 8'd1;
          if (rx_cnt_q == 8'd1) rx_st_q <= R_HDR;
        end
        R_DROP: if (noc_i_valid) begin
          rx_cnt_q <= rx_cnt_q - 8'd1;
          if (rx_cnt_q == 8'd1) rx_st_q <= R_HDR;
        end
        default: rx_st_q <= R_HDR;
      endcase
    end
  end

  // Handshake and data outputs are decoded from state and forced low during reset.
  always_comb begin
    noc_e_dat    = '0;
    noc_e_valid  = 1'b0;
    tx_req_ready = 1'b0;
    tx_ready     = 1'b0;
    case (tx_st_q)
      T_IDLE: tx_req_ready = 1'b1;
      T_HDR: begin
        noc_e_valid = 1'b1;
        noc_e_dat   = {16'h0000, tx_cnt_q, MY_Y, MY_X, tx_dst_q};
      end
      T_BODY: begin
        noc_e_valid = tx_valid;
        noc_e_dat   = tx_dat;
        tx_ready    = noc_e_ready;
      end
      T_DISC: tx_ready = 1'b1;
      default: ;
    endcase
    if (!reset) begin
      noc_e_dat    = '0;
      noc_e_valid  = 1'b0;
      tx_req_ready = 1'b0;
      tx_ready     = 1'b0;
    end
  end

  always_comb begin
    noc_i_ready = 1'b0;
    rx_valid    = 1'b0;
    rx_dat      = '0;
    rx_last     = 1'b0;
    case (rx_st_q)
      R_HDR:  noc_i_ready = 1'b1;
      R_BODY: begin
        noc_i_ready = rx_ready;
        rx_valid    = noc_i_valid;
        rx_dat      = noc_i_dat;
        rx_last     = (rx_cnt_q == 8'd1);
      end
      R_DROP: noc_i_ready = 1'b1;
      default: ;
    endcase
    if (!reset) begin
      noc_i_ready = 1'b0;
      rx_valid    = 1'b0;
      rx_dat      = '0;
      rx_last     = 1'b0;
    end
  end

  assign tx_err       = tx_err_q;
  assign rx_hdr_valid = rx_hdr_q;
  assign rx_src_x     = rx_src_x_q;
  assign rx_src_y     = rx_src_y_q;
  assign rx_len       = rx_len_q;
  assign rx_drop_cnt  = rx_drop_q;
endmodule

// File: tb/tb_fwnoc_host_ep.sv
// Directed bench for fwnoc_host_ep at tile (1,2): TX packetize/stall/self-discard,
// RX match/drop saturation, and mid-packet reset.
module tb_fwnoc_host_ep;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] noc_e_dat;
  logic        noc_e_valid;
  logic        noc_e_ready = 1'b0;
  logic [31:0] noc_i_dat = '0;
  logic        noc_i_valid = 1'b0;
  logic        noc_i_ready;
  logic        tx_req_valid = 1'b0;
  logic        tx_req_ready;
  logic [1:0]  tx_dst_x = '0, tx_dst_y = '0;
  logic [7:0]  tx_len = '0;
  logic [31:0] tx_dat = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        tx_err;
  logic        rx_hdr_valid;
  logic [1:0]  rx_src_x, rx_src_y;
  logic [7:0]  rx_len;
  logic [31:0] rx_dat;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        rx_last;
  logic [7:0]  rx_drop_cnt;

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  fwnoc_host_ep #(.X_ID(1), .Y_ID(2)) dut (
    .clock(clock), .reset(reset),
    .noc_e_dat(noc_e_dat), .noc_e_valid(noc_e_valid), .noc_e_ready(noc_e_ready),
    .noc_i_dat(noc_i_dat), .noc_i_valid(noc_i_valid), .noc_i_ready(noc_i_ready),
    .tx_req_valid(tx_req_valid), .tx_req_ready(tx_req_ready),
    .tx_dst_x(tx_dst_x), .tx_dst_y(tx_dst_y), .tx_len(tx_len),
    .tx_dat(tx_dat), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_err(tx_err),
    .rx_hdr_valid(rx_hdr_valid), .rx_src_x(rx_src_x), .rx_src_y(rx_src_y),
    .rx_len(rx_len), .rx_dat(rx_dat), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_last(rx_last), .rx_drop_cnt(rx_drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // mode 0: noc_e_ready always 1; mode 1: ready pattern 1,0,0,1 repeating
  task automatic send_tx(input logic [1:0] dx, input logic [1:0] dy, input logic [7:0] len,
                         input int mode, input logic [31:0] hdr, input logic [31:0] base);
    logic [31:0] got[$];
    int idx = 0;
    int cyc = 0;
    logic pv = 1'b0, pr = 1'b0;
    logic [31:0] pd = '0;
    @(negedge clock);
    tx_req_valid = 1'b1; tx_dst_x = dx; tx_dst_y = dy; tx_len = len;
    #1 chk("tx_req_ready", {31'b0, tx_req_ready}, 32'd1);
    @(negedge clock);
    tx_req_valid = 1'b0;
    while (got.size() < int'(len) + 1 && cyc < 60) begin
      noc_e_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      tx_valid = (idx < int'(len));
      tx_dat = base + idx;
      #1;
      if (pv && !pr) begin
        chk("e_hold_valid", {31'b0, noc_e_valid}, 32'd1);
        chk("e_hold_dat", noc_e_dat, pd);
      end
      if (noc_e_valid && noc_e_ready) got.push_back(noc_e_dat);
      if (tx_valid && tx_ready) idx++;
      pv = noc_e_valid; pr = noc_e_ready; pd = noc_e_dat; cyc++;
      @(negedge clock);
    end
    tx_valid = 1'b0; noc_e_ready = 1'b0;
    #1;
    chk("tx_word_count", got.size(), int'(len) + 1);
    for (int i = 0; i < got.size(); i++)
      chk("tx_word", got[i], (i == 0) ? hdr : base + i - 1);
    chk("tx_idle_req_ready", {31'b0, tx_req_ready}, 32'd1);
    chk("tx_idle_e_valid", {31'b0, noc_e_valid}, 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_req_ready", {31'b0, tx_req_ready}, 32'd0);
    chk("rst_i_ready", {31'b0, noc_i_ready}, 32'd0);
    chk("rst_drop", {24'b0, rx_drop_cnt}, 32'd0);
    @(negedge clock); reset = 1'b1;
    #1 chk("post_rst_req_ready", {31'b0, tx_req_ready}, 32'd1);
    chk("post_rst_i_ready", {31'b0, noc_i_ready}, 32'd1);

    // dst (3,0) src (1,2) len 3 -> 0x0393
    send_tx(2'd3, 2'd0, 8'd3, 0, 32'h0000_0393, 32'hA000_0000);
    send_tx(2'd3, 2'd0, 8'd3, 1, 32'h0000_0393, 32'hB000_0000);

    // self-addressed: discard two words, tx_err pulse
    @(negedge clock);
    tx_req_valid = 1'b1; tx_dst_x = 2'd1; tx_dst_y = 2'd2; tx_len = 8'd2;
    @(negedge clock);
    tx_req_valid = 1'b0; tx_valid = 1'b1; tx_dat = 32'hC0; noc_e_ready = 1'b1;
    #1 chk("self_err_pulse", {31'b0, tx_err}, 32'd1);
    chk("self_tx_ready0", {31'b0, tx_ready}, 32'd1);
    chk("self_e_valid0", {31'b0, noc_e_valid}, 32'd0);
    @(negedge clock);
    tx_dat = 32'hC1;
    #1 chk("self_err_once", {31'b0, tx_err}, 32'd0);
    chk("self_tx_ready1", {31'b0, tx_ready}, 32'd1);
    chk("self_e_valid1", {31'b0, noc_e_valid}, 32'd0);
    @(negedge clock);
    tx_valid = 1'b0; noc_e_ready = 1'b0;
    #1 chk("self_done_tx_ready", {31'b0, tx_ready}, 32'd0);
    chk("self_done_req_ready", {31'b0, tx_req_ready}, 32'd1);

    // RX matching packet 0x249 + D0,D1
    @(negedge clock);
    noc_i_valid = 1'b1; noc_i_dat = 32'h0000_0249; rx_ready = 1'b1;
    #1 chk("rx_hdr_ready", {31'b0, noc_i_ready}, 32'd1);
    chk("rx_hdr_nopulse", {31'b0, rx_hdr_valid}, 32'd0);
    @(negedge clock);
    noc_i_dat = 32'hD0D0_0000;
    #1 chk("rx_hdr_pulse", {31'b0, rx_hdr_valid}, 32'd1);
    chk("rx_src", {28'b0, rx_src_y, rx_src_x}, {28'b0, 2'd1, 2'd0});
    chk("rx_len", {24'b0, rx_len}, 32'd2);
    chk("rx_valid_d0", {31'b0, rx_valid}, 32'd1);
    chk("rx_dat_d0", rx_dat, 32'hD0D0_0000);
    chk("rx_last_d0", {31'b0, rx_last}, 32'd0);
    @(negedge clock);
    noc_i_dat = 32'hD1D1_0001;
    #1 chk("rx_hdr_pulse_once", {31'b0, rx_hdr_valid}, 32'd0);
    chk("rx_dat_d1", rx_dat, 32'hD1D1_0001);
    chk("rx_last_d1", {31'b0, rx_last}, 32'd1);
    @(negedge clock);
    noc_i_valid = 1'b0;
    #1 chk("rx_back_hdr", {31'b0, noc_i_ready}, 32'd1);
    chk("rx_idle_valid", {31'b0, rx_valid}, 32'd0);

    // 300 misaddressed packets, len 1 -> saturating drop counter
    for (int p = 0; p < 300; p++) begin
      @(negedge clock);
      noc_i_valid = 1'b1; noc_i_dat = 32'h0000_0100;
      @(negedge clock);
      noc_i_dat = 32'hEE00_0000 + p;
      #1 chk("drop_ready", {31'b0, noc_i_ready}, 32'd1);
      chk("drop_no_valid", {31'b0, rx_valid}, 32'd0);
      chk("drop_no_hdr", {31'b0, rx_hdr_valid}, 32'd0);
      if (p == 0) chk("drop_first", {24'b0, rx_drop_cnt}, 32'd1);
    end
    @(negedge clock);
    noc_i_valid = 1'b0;
    #1 chk("drop_saturated", {24'b0, rx_drop_cnt}, 32'd255);
    chk("rx_len_held", {24'b0, rx_len}, 32'd2);

    // reset in T_BODY with one word left
    @(negedge clock);
    tx_req_valid = 1'b1; tx_dst_x = 2'd0; tx_dst_y = 2'd0; tx_len = 8'd2;
    @(negedge clock);
    tx_req_valid = 1'b0; noc_e_ready = 1'b1;
    @(negedge clock);
    tx_valid = 1'b1; tx_dat = 32'hF0;
    @(negedge clock);
    tx_dat = 32'hF1;
    #1 chk("body_valid", {31'b0, noc_e_valid}, 32'd1);
    reset = 1'b0;
    #1 chk("mid_rst_e_valid", {31'b0, noc_e_valid}, 32'd0);
    chk("mid_rst_tx_ready", {31'b0, tx_ready}, 32'd0);
    chk("mid_rst_req_ready", {31'b0, tx_req_ready}, 32'd0);
    chk("mid_rst_i_ready", {31'b0, noc_i_ready}, 32'd0);
    chk("mid_rst_drop", {24'b0, rx_drop_cnt}, 32'd0);
    chk("mid_rst_rx_len", {24'b0, rx_len}, 32'd0);
    @(negedge clock);
    reset = 1'b1; tx_valid = 1'b0; noc_e_ready = 1'b0;
    #1 chk("rel_req_ready", {31'b0, tx_req_ready}, 32'd1);
    chk("rel_e_valid", {31'b0, noc_e_valid}, 32'd0);
    // dst (2,1) src (1,2) len 0 -> 0x0096
    send_tx(2'd2, 2'd1, 8'd0, 0, 32'h0000_0096, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hang want finish");
    $fatal(1);
  end
endmodule
